// File: rtl/alu_if.sv
// Bus-side interface of the datapath add/subtract unit.
// The CPU control side (master) drives the bus and the load/sub controls.
// The ALU (slave) returns G, plus the zero/carry/ovf flags when ALU_FLAGS_EN is defined.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] buswire;
    logic             ain;
    logic             gin;
    logic             sub;
    logic [WIDTH-1:0] aluout;
`ifdef ALU_FLAGS_EN
    logic             zero;
    logic             carry;
    logic             ovf;
`endif

    modport master (
        output buswire, ain, gin, sub,
`ifdef ALU_FLAGS_EN
        input  zero, carry, ovf,
`endif
        input  aluout
    );

    modport slave (
        input  buswire, ain, gin, sub,
`ifdef ALU_FLAGS_EN
        output zero, carry, ovf,
`endif
        output aluout
    );
endinterface

// File: rtl/alu.sv
// Datapath add/subtract unit of the structural CPU.
// Register A loads from the shared bus.  Register G loads A + bus or A - bus,
// computed by a ripple chain of full-adder cells.  Subtraction inverts the bus
// operand and sets the carry-in to 1.  aluout is G and has no combinational
// path from the bus.
// Optional feature macro: ALU_FLAGS_EN.  When it is defined, the block adds
// zero/carry/ovf flags.  Carry and ovf are captured with G; zero is decoded from G.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic  i_clock,
    input  logic  i_reset,
    alu_if.slave  bus
);
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_sum;
`ifdef ALU_FLAGS_EN
    logic             w_cin_msb;
    logic             w_cout;
    logic             r_carry;
    logic             r_ovf;
`endif

    assign w_opb = bus.buswire ^ {WIDTH{bus.sub}};

    // Ripple-carry chain of full-adder cells, LSB first, with carry-in = sub
    always_comb begin : p_ripple
        logic w_ripple;
        w_ripple = bus.sub;
        w_sum    = '0;
`ifdef ALU_FLAGS_EN
        w_cin_msb = 1'b0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
`ifdef ALU_FLAGS_EN
            if (i == WIDTH - 1) w_cin_msb = w_ripple;
`endif
            w_sum[i] = r_a[i] ^ w_opb[i] ^ w_ripple;
            w_ripple = (r_a[i] & w_opb[i]) | (w_ripple & (r_a[i] ^ w_opb[i]));
        end
`ifdef ALU_FLAGS_EN
        w_cout = w_ripple;
`endif
    end

    // Operand register A: loads the bus on ain; reset takes priority
    always_ff @(posedge i_clock) begin
        if (i_reset)      r_a <= '0;
        else if (bus.ain) r_a <= bus.buswire;
    end

    // Result register G: loads the sum formed from the pre-edge A on gin
    always_ff @(posedge i_clock) begin
        if (i_reset)      r_g <= '0;
        else if (bus.gin) r_g <= w_sum;
    end

    assign bus.aluout = r_g;

`ifdef ALU_FLAGS_EN
    // Carry and signed-overflow flags are captured together with G
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.gin) begin
            r_carry <= w_cout;
            r_ovf   <= w_cin_msb ^ w_cout;
        end
    end

    assign bus.zero  = (r_g == '0);
    assign bus.carry = r_carry;
    assign bus.ovf   = r_ovf;
`endif
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu.  After each clock edge, the stimulus process pushes the
// hand-computed expected aluout (and flags, when ALU_FLAGS_EN is defined).  A
// separate monitor process pops each entry on the falling edge and compares it.
module tb_alu;
    localparam int W = 16;

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic         z;
        logic         c;
        logic         o;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    logic [W-1:0] hold_val;

    alu_if #(.WIDTH(W)) bif ();

    alu #(.WIDTH(W)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    // Drive one edge's worth of inputs, then queue the expected post-edge state.
    task automatic step(input string name, input logic r, input logic a, input logic g,
                        input logic s, input logic [W-1:0] b, input logic [W-1:0] e_out,
                        input logic e_c, input logic e_o);
        exp_t e;
        @(negedge clk);
        rst = r; bif.ain = a; bif.gin = g; bif.sub = s; bif.buswire = b;
        @(posedge clk);
        #1;
        e.name = name; e.out = e_out; e.z = (e_out == '0); e.c = e_c; e.o = e_o;
        q.push_back(e);
    endtask

    // Monitor: compare every queued expectation against the DUT outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (bif.aluout !== e.out) begin
                    n_fail++;
                    $display("FAIL %s aluout: got %h expected %h", e.name, bif.aluout, e.out);
                end
`ifdef ALU_FLAGS_EN
                n_checks++;
                if (bif.zero !== e.z) begin
                    n_fail++;
                    $display("FAIL %s zero: got %b expected %b", e.name, bif.zero, e.z);
                end
                n_checks++;
                if (bif.carry !== e.c) begin
                    n_fail++;
                    $display("FAIL %s carry: got %b expected %b", e.name, bif.carry, e.c);
                end
                n_checks++;
                if (bif.ovf !== e.o) begin
                    n_fail++;
                    $display("FAIL %s ovf: got %b expected %b", e.name, bif.ovf, e.o);
                end
`endif
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed vectors
    initial begin
        rst = 1'b1; bif.ain = 1'b0; bif.gin = 1'b0; bif.sub = 1'b0; bif.buswire = '0;

        //    name          rst  ain  gin  sub  bus       aluout    carry ovf
        step("reset",       1'b1,1'b1,1'b1,1'b0,16'hFFFF, 16'h0000, 1'b0, 1'b0);
        step("reset_a0",    1'b0,1'b0,1'b1,1'b0,16'h0001, 16'h0001, 1'b0, 1'b0);
        step("load_a1234",  1'b0,1'b1,1'b0,1'b1,16'h1234, 16'h0001, 1'b0, 1'b0);
        step("add",         1'b0,1'b0,1'b1,1'b0,16'h0F0F, 16'h2143, 1'b0, 1'b0);
        step("load_a0005",  1'b0,1'b1,1'b0,1'b0,16'h0005, 16'h2143, 1'b0, 1'b0);
        step("sub_borrow",  1'b0,1'b0,1'b1,1'b1,16'h0007, 16'hFFFE, 1'b0, 1'b0);
        step("load_a7fff",  1'b0,1'b1,1'b0,1'b0,16'h7FFF, 16'hFFFE, 1'b0, 1'b0);
        step("add_ovf",     1'b0,1'b0,1'b1,1'b0,16'h0001, 16'h8000, 1'b0, 1'b1);
        step("load_affff",  1'b0,1'b1,1'b0,1'b0,16'hFFFF, 16'h8000, 1'b0, 1'b1);
        step("add_wrap",    1'b0,1'b0,1'b1,1'b0,16'h0001, 16'h0000, 1'b1, 1'b0);
        step("load_a0010",  1'b0,1'b1,1'b0,1'b0,16'h0010, 16'h0000, 1'b1, 1'b0);
        step("simul",       1'b0,1'b1,1'b1,1'b0,16'h0003, 16'h0013, 1'b0, 1'b0);
        step("simul_a",     1'b0,1'b0,1'b1,1'b0,16'h0000, 16'h0003, 1'b0, 1'b0);
        step("sub_equal",   1'b0,1'b0,1'b1,1'b1,16'h0003, 16'h0000, 1'b1, 1'b0);
        step("load_a8000",  1'b0,1'b1,1'b0,1'b1,16'h8000, 16'h0000, 1'b1, 1'b0);
        step("sub_ovf",     1'b0,1'b0,1'b1,1'b1,16'h0001, 16'h7FFF, 1'b1, 1'b1);

        hold_val = 16'h7FFF;
        for (int i = 0; i < 10; i++) begin
            step($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                 16'($urandom), hold_val, 1'b1, 1'b1);
        end
        step("hold_x",      1'b0,1'b0,1'b0,1'bx,16'hxxxx, 16'h7FFF, 1'b1, 1'b1);

        step("reset_again", 1'b1,1'b0,1'b1,1'b0,16'h1111, 16'h0000, 1'b0, 1'b0);
        step("post_reset",  1'b0,1'b0,1'b1,1'b0,16'h0042, 16'h0042, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
